// File: rtl/alu_reg_sequencer.sv
// Operand sequencer in front of alu8: 8-bit register file, one command in flight,
// registered ALU operands, write-back and a response handshake.
module alu_reg_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic              cmd_imm_en,
    input  logic [7:0]        cmd_imm,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_sel,
    input  logic [7:0]        alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic [REG_AW-1:0] rsp_rd,
    output logic              rsp_zero,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_exec;
    logic [7:0]        r_rf [NUM_REGS];
    logic [7:0]        r_alu_a;
    logic [7:0]        r_alu_b;
    logic [2:0]        r_alu_sel;
    logic [REG_AW-1:0] r_rd;
    logic [7:0]        r_rsp_data;
    logic [REG_AW-1:0] r_rsp_rd;
    logic              r_rsp_zero;
    logic [7:0]        w_rs1_val;
    logic [7:0]        w_rs2_val;

    // Indices with no backing entry read as zero; matching by loop keeps that implicit.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cmd_rs1 == REG_AW'(i)) w_rs1_val = r_rf[i];
            if (cmd_rs2 == REG_AW'(i)) w_rs2_val = r_rf[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_exec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = EXEC;
                end
            end
            EXEC: begin
                w_exec = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_rd       <= '0;
            r_rsp_data <= '0;
            r_rsp_rd   <= '0;
            r_rsp_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a   <= w_rs1_val;
                r_alu_b   <= cmd_imm_en ? cmd_imm : w_rs2_val;
                r_alu_sel <= cmd_op;
                r_rd      <= cmd_rd;
            end
            if (w_exec) begin
                r_rsp_data <= alu_result;
                r_rsp_rd   <= r_rd;
                r_rsp_zero <= (alu_result == 8'h00);
            end
        end
    end

    // Out-of-range destinations match no entry, so the write is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
        end else if (w_exec) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (r_rd == REG_AW'(i)) r_rf[i] <= alu_result;
            end
        end
    end

    assign cmd_ready = rst_n && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign rsp_data  = r_rsp_data;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Bench for alu_reg_sequencer: reference alu8, transaction-level model checked every
// cycle, plus directed scenarios with literal expected results.
module tb_alu_reg_sequencer;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = '0;
    logic [AW-1:0] cmd_rd = '0;
    logic [AW-1:0] cmd_rs1 = '0;
    logic [AW-1:0] cmd_rs2 = '0;
    logic          cmd_imm_en = 1'b0;
    logic [7:0]    cmd_imm = '0;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [7:0]    alu_result;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [7:0]    rsp_data;
    logic [AW-1:0] rsp_rd;
    logic          rsp_zero;
    logic          busy;

    alu_reg_sequencer #(.NUM_REGS(NR), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel);
        case (sel)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return ~(a | b);
            default: return ~(a ^ b);
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_sel);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding command; phase 0 = computing, 1 = response pending.
    logic [7:0]    m_rf [NR];
    bit            m_out;
    int            m_phase;
    logic [7:0]    m_a, m_b, m_data;
    logic [2:0]    m_sel;
    logic [AW-1:0] m_dst, m_rd;
    bit            m_zero;

    function automatic logic [7:0] m_read(input logic [AW-1:0] idx);
        return (int'(idx) < NR) ? m_rf[idx] : 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_rf[i] = 8'h00;
            m_out = 0; m_phase = 0;
            m_a = 0; m_b = 0; m_sel = 0; m_dst = 0;
            m_data = 0; m_rd = 0; m_zero = 0;
        end else if (!m_out) begin
            if (cmd_valid) begin
                m_a     = m_read(cmd_rs1);
                m_b     = cmd_imm_en ? cmd_imm : m_read(cmd_rs2);
                m_sel   = cmd_op;
                m_dst   = cmd_rd;
                m_out   = 1;
                m_phase = 0;
            end
        end else if (m_phase == 0) begin
            m_data = alu_ref(m_a, m_b, m_sel);
            m_rd   = m_dst;
            m_zero = (m_data == 8'h00);
            if (int'(m_dst) < NR) m_rf[m_dst] = m_data;
            m_phase = 1;
        end else if (rsp_ready) begin
            m_out = 0;
        end
    end

    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, (rst_n && !m_out));
        chk("busy", busy, m_out);
        chk("rsp_valid", rsp_valid, (m_out && m_phase == 1));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", alu_sel, m_sel);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_rd", rsp_rd, m_rd);
        chk("rsp_zero", rsp_zero, m_zero);
    end

    task automatic send(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic ie, input logic [7:0] imm);
        bit ok;
        ok = 0;
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_en = ie; cmd_imm = imm; cmd_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (cmd_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("accept_timeout", ok, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic get(output logic [7:0] d, output logic [AW-1:0] r, output logic z);
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        chk("rsp_timeout", ok, 1);
        d = rsp_data; r = rsp_rd; z = rsp_zero;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic ie, input logic [7:0] imm,
                       output logic [7:0] d, output logic [AW-1:0] r, output logic z);
        send(op, rd, rs1, rs2, ie, imm);
        get(d, r, z);
    endtask

    logic [7:0]    d;
    logic [AW-1:0] r;
    logic          z;
    logic [7:0]    sweep_exp [8];

    initial begin
        sweep_exp = '{8'hD9, 8'hBB, 8'h0A, 8'hCF, 8'hC5, 8'hF5, 8'h30, 8'h3A};
        #3;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        #9 rst_n = 1'b1;

        // Immediate load and response latency
        send(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
        @(negedge clk);
        chk("lat_exec_no_valid", rsp_valid, 0);
        get(d, r, z);
        chk("t1_data", d, 8'h05);
        chk("t1_rd", r, 3'd1);
        chk("t1_zero", z, 0);

        run(3'd1, 3'd2, 3'd1, 3'd0, 1'b1, 8'h06, d, r, z);
        chk("t2_wrap", d, 8'hFF);
        run(3'd0, 3'd3, 3'd2, 3'd0, 1'b1, 8'h01, d, r, z);
        chk("t2_zero_data", d, 8'h00);
        chk("t2_zero_flag", z, 1);

        // Response stall with a pending, changing upstream command
        send(3'd0, 3'd5, 3'd1, 3'd0, 1'b1, 8'h10);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'(i); cmd_rd = 3'd6; cmd_rs1 = 3'd0;
            cmd_imm_en = 1'b1; cmd_imm = 8'h21;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 8'h15);
            chk("stall_ready", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_op = 3'd0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("stall_idle_ready", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        get(d, r, z);
        chk("stall_pending_data", d, 8'h21);
        chk("stall_pending_rd", r, 3'd6);

        // Opcode sweep
        run(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'hCA, d, r, z);
        chk("sweep_setup", d, 8'hCA);
        for (int op = 0; op < 8; op++) begin
            run(3'(op), 3'd6, 3'd1, 3'd0, 1'b1, 8'h0F, d, r, z);
            chk("sweep_data", d, sweep_exp[op]);
        end

        // Same register as both sources and destination
        run(3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 8'h10, d, r, z);
        run(3'd0, 3'd4, 3'd4, 3'd4, 1'b0, 8'h00, d, r, z);
        chk("alias_data", d, 8'h20);
        run(3'd0, 3'd7, 3'd4, 3'd0, 1'b1, 8'h00, d, r, z);
        chk("alias_readback", d, 8'h20);

        // Reset in the middle of EXEC
        send(3'd0, 3'd5, 3'd0, 3'd0, 1'b1, 8'h77);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_alu_b", alu_b, 0);
        chk("midrst_rsp_data", rsp_data, 0);
        chk("midrst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        run(3'd0, 3'd7, 3'd5, 3'd0, 1'b1, 8'h00, d, r, z);
        chk("midrst_no_writeback", d, 8'h00);
        chk("midrst_zero", z, 1);

        // Randomized traffic, checked by the per-cycle monitor
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_op     = 3'($urandom);
            cmd_rd     = 3'($urandom);
            cmd_rs1    = 3'($urandom);
            cmd_rs2    = 3'($urandom);
            cmd_imm_en = 1'($urandom_range(0, 1));
            cmd_imm    = 8'($urandom);
            rsp_ready  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("drain_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
